// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the async FIFO read-side logic.
package async_fifo_pkg;

  localparam int ASYNC_FIFO_DWIDTH = 8;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_RUN,
    RD_FLUSH
  } rd_state_e;

  // Bits needed to index 'value' entries; never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/async_fifo_rd_buf.sv
// Small synchronous FIFO that parks words captured from the async FIFO until
// the downstream stream accepts them.
module async_fifo_rd_buf import async_fifo_pkg::*; #(
  parameter int DWIDTH = ASYNC_FIFO_DWIDTH,
  parameter int DEPTH  = 3,
  localparam int PW    = clog2(DEPTH),
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              rd_i,
  input  logic              clr_i,
  output logic [CW-1:0]     cnt_o,
  output logic [DWIDTH-1:0] head_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (wr_i) wp_d = ptr_inc(wp_q);
      if (rd_i) rp_d = ptr_inc(rp_q);
      cnt_d = cnt_q + CW'(wr_i) - CW'(rd_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_i && !clr_i) begin
      mem_q[wp_q] <= wdata_i;
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = mem_q[rp_q];

  overflow_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_i && !rd_i && !clr_i && cnt_q == CW'(DEPTH)))
    else $error("async_fifo_rd_buf: capture into full buffer");

endmodule

// File: rtl/async_fifo_rd_drain.sv
// Read-side consumer for the async FIFO: pops on credit, tracks the fixed
// pop-to-data latency, and re-presents words as a valid/ready stream.
module async_fifo_rd_drain import async_fifo_pkg::*; #(
  parameter int DWIDTH = ASYNC_FIFO_DWIDTH,
  parameter int RD_LAT = 1,
  parameter int BUF_D  = RD_LAT + 2,
  parameter int CWIDTH = 16
) (
  input  logic              rclk,
  input  logic              reset_L,
  input  logic              en,
  input  logic              flush,
  output logic              pop,
  input  logic [DWIDTH-1:0] rdata,
  input  logic              empty,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [CWIDTH-1:0] word_cnt
);

  localparam int CNT_W = clog2(BUF_D + 1);
  localparam int IF_W  = clog2(RD_LAT + 1);
  localparam int SUM_W = CNT_W + 1;

  rd_state_e         state_q, state_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [IF_W-1:0]   inflight;
  logic [CNT_W-1:0]  buf_cnt;
  logic [DWIDTH-1:0] buf_head;
  logic [CWIDTH-1:0] word_cnt_q, word_cnt_d;
  logic              capture, buf_wr, buf_clr, xfer, credit_ok;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + IF_W'(pipe_q[i]);
  end

  // Words already parked plus words still in the FIFO's read pipe must fit.
  assign credit_ok = (SUM_W'(buf_cnt) + SUM_W'(inflight)) < SUM_W'(BUF_D);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (flush)   state_d = RD_FLUSH;
        else if (en) state_d = RD_RUN;
      end
      RD_RUN: begin
        pop = !empty && credit_ok;
        if (flush)    state_d = RD_FLUSH;
        else if (!en) state_d = RD_IDLE;
      end
      RD_FLUSH: begin
        pop = !empty;
        if (!flush && empty && inflight == '0) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    pipe_d[0] = pop;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  assign capture   = pipe_q[RD_LAT-1];
  assign buf_wr    = capture && (state_q != RD_FLUSH);
  assign buf_clr   = (state_d == RD_FLUSH) && (state_q != RD_FLUSH);
  assign out_valid = (buf_cnt != '0) && (state_q != RD_FLUSH);
  assign out_data  = buf_head;
  assign xfer      = out_valid && out_ready;
  assign busy      = (state_q != RD_IDLE) || (inflight != '0) || (buf_cnt != '0);

  assign word_cnt_d = xfer ? word_cnt_q + CWIDTH'(1) : word_cnt_q;
  assign word_cnt   = word_cnt_q;

  always_ff @(posedge rclk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= RD_IDLE;
      pipe_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pipe_q     <= pipe_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  async_fifo_rd_buf #(
    .DWIDTH (DWIDTH),
    .DEPTH  (BUF_D)
  ) u_buf (
    .clk_i   (rclk),
    .rst_ni  (reset_L),
    .wr_i    (buf_wr),
    .wdata_i (rdata),
    .rd_i    (xfer),
    .clr_i   (buf_clr),
    .cnt_o   (buf_cnt),
    .head_o  (buf_head)
  );

endmodule
